// File: rtl/proc_instr_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_instr_feeder_if : program-load, control and instruction bus          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface proc_instr_feeder_if #(
    parameter int N  = 9,
    parameter int AW = 4
);
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [N-1:0]  ld_data;
    logic          start;
    logic [AW:0]   len;
    logic          done;
    logic [N-1:0]  din;
    logic          run;
    logic          busy;
    logic          finished;
    logic          err;
    logic [AW:0]   pc;

    modport slave (
        input  ld_en, ld_addr, ld_data, start, len, done,
        output din, run, busy, finished, err, pc
    );

    modport master (
        output ld_en, ld_addr, ld_data, start, len, done,
        input  din, run, busy, finished, err, pc
    );
endinterface
`default_nettype wire

// File: rtl/proc_instr_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_instr_feeder : program store that issues words to proc on Run/Done  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module proc_instr_feeder #(
    parameter int N     = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TMO   = 64
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    proc_instr_feeder_if.slave   bus
);
    localparam int          CW         = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [2:0]  c_OP_MVI   = 3'b001;
    localparam logic [CW-1:0] c_TMO_LAST = CW'(TMO - 1);
    localparam logic [AW:0] c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE      = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_IMM   = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  din_q, din_d;
    logic          run_q, run_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic          err_q, err_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  w_rd_word;
    logic [N-1:0]  w_word0;

    // Program store is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (bus.ld_en && !busy_q) begin
            mem_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign w_rd_word = mem_q[pc_q[AW-1:0]];
    assign w_word0   = mem_q[0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each state's outputs are registered on the edge that enters it, so the
    // ISSUE state is exactly the cycle in which Run is visible to proc.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        run_d   = 1'b0;
        fin_d   = 1'b0;
        err_d   = err_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    err_d = 1'b0;
                    if (bus.len == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        len_d   = (bus.len > c_DEPTH) ? c_DEPTH : bus.len;
                        din_d   = w_word0;
                        run_d   = 1'b1;
                        pc_d    = c_ONE;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (din_q[N-1 -: 3] == c_OP_MVI) begin
                    if (pc_q < len_q) begin
                        din_d   = w_rd_word;
                        pc_d    = pc_q + c_ONE;
                        state_d = S_IMM;
                    end else begin
                        din_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_IMM: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.done) begin
                    if (pc_q == len_q) begin
                        fin_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        din_d   = w_rd_word;
                        run_d   = 1'b1;
                        pc_d    = pc_q + c_ONE;
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == c_TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.din      = din_q;
    assign bus.run      = run_q;
    assign bus.busy     = busy_q;
    assign bus.finished = fin_q;
    assign bus.err      = err_q;
    assign bus.pc       = pc_q;

endmodule
`default_nettype wire
